// File: rtl/sparse_run_if.sv
// Sparse run controller bus: configuration, DMA/scheduler status, result
// stream and output BRAM write port grouped in one bundle.
// The master side drives configuration and pipeline status.
// The slave side is sparse_run_ctrl.
interface sparse_run_if #(
  parameter int OUT_ADDR_W = 10,
  parameter int DATA_W     = 32
);
  logic                  cfg_start;
  logic                  cfg_abort;
  logic [31:0]           cfg_total_blocks;
  logic [15:0]           cfg_meta_words;
  logic                  dma_word_valid;
  logic                  sched_start;
  logic                  sched_done;
  logic                  sched_busy;
  logic                  res_valid;
  logic [DATA_W-1:0]     res_data;
  logic                  res_ready;
  logic                  out_wr_en;
  logic [OUT_ADDR_W-1:0] out_wr_addr;
  logic [DATA_W-1:0]     out_wr_data;
  logic                  busy;
  logic                  done_pulse;
  logic                  error;
  logic [1:0]            err_code;
  logic [31:0]           blocks_done;
  logic [31:0]           perf_cycles;

  modport master (
    output cfg_start, cfg_abort, cfg_total_blocks, cfg_meta_words,
           dma_word_valid, sched_done, sched_busy, res_valid, res_data,
    input  sched_start, res_ready, out_wr_en, out_wr_addr, out_wr_data,
           busy, done_pulse, error, err_code, blocks_done, perf_cycles
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_total_blocks, cfg_meta_words,
           dma_word_valid, sched_done, sched_busy, res_valid, res_data,
    output sched_start, res_ready, out_wr_en, out_wr_addr, out_wr_data,
           busy, done_pulse, error, err_code, blocks_done, perf_cycles
  );
endinterface

// File: rtl/sparse_run_ctrl.sv
// Run-level sequencer for the sparse pipeline.
// It counts metadata words, then starts the scheduler once. It accepts
// results and writes them to the output BRAM at incrementing addresses.
// It flags overflow, underrun and stall timeouts, and pulses done once
// per run.
// Optional feature macro: SPARSE_RUN_PERF_EN enables the perf_cycles
// run-cycle counter. Without the macro, perf_cycles is tied to zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for cfg_start
// LOAD  | counting metadata words accepted by meta_decode
// RUN   | scheduler started; accepting results into the output BRAM
// DRAIN | all results in; waiting for sched_busy to fall
// DONE  | single cycle carrying done_pulse
// ERR   | sticky error; left by cfg_abort or cfg_start
module sparse_run_ctrl #(
  parameter int OUT_ADDR_W     = 10,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic        clk,
  input logic        rst_n,
  sparse_run_if.slave bus
);

  localparam int          WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [32:0] DEPTH = 33'd1 << OUT_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t                state;
  logic [31:0]           total_q;
  logic [15:0]           meta_q;
  logic [15:0]           meta_cnt;
  logic [WD_W-1:0]       wdog;
  logic [31:0]           blocks_q;
  logic [OUT_ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0]     wr_data_q;
  logic                  wr_en_q;
  logic                  sched_start_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  error_q;
  logic [1:0]            err_code_q;

  logic        hs;
  logic        last_hs;
  logic        wd_expire;
  logic        oversize;
  logic [15:0] meta_next;

  assign hs        = bus.res_valid && (state == S_RUN);
  assign last_hs   = hs && ((blocks_q + 32'd1) == total_q);
  assign wd_expire = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign oversize  = {1'b0, bus.cfg_total_blocks} > DEPTH;
  assign meta_next = meta_cnt + {15'd0, bus.dma_word_valid};

  assign bus.res_ready   = (state == S_RUN);
  assign bus.sched_start = sched_start_q;
  assign bus.out_wr_en   = wr_en_q;
  assign bus.out_wr_addr = wr_addr_q;
  assign bus.out_wr_data = wr_data_q;
  assign bus.busy        = busy_q;
  assign bus.done_pulse  = done_q;
  assign bus.error       = error_q;
  assign bus.err_code    = err_code_q;
  assign bus.blocks_done = blocks_q;

  // Run sequencing FSM with registered pulses, write port and status flags.
  // Writes for results accepted before an abort still go out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      total_q       <= '0;
      meta_q        <= '0;
      meta_cnt      <= '0;
      wdog          <= '0;
      blocks_q      <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
      sched_start_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      sched_start_q <= 1'b0;
      done_q        <= 1'b0;
      wr_en_q       <= hs;
      if (hs) begin
        blocks_q  <= blocks_q + 32'd1;
        wr_addr_q <= blocks_q[OUT_ADDR_W-1:0];
        wr_data_q <= bus.res_data;
      end
      if (bus.cfg_abort) begin
        state      <= S_IDLE;
        busy_q     <= 1'b0;
        error_q    <= 1'b0;
        err_code_q <= 2'd0;
      end else begin
        case (state)
          S_IDLE, S_ERR: begin
            if (bus.cfg_start) begin
              error_q    <= 1'b0;
              err_code_q <= 2'd0;
              blocks_q   <= '0;
              wr_addr_q  <= '0;
              meta_cnt   <= '0;
              wdog       <= '0;
              total_q    <= bus.cfg_total_blocks;
              meta_q     <= bus.cfg_meta_words;
              if (oversize) begin
                state      <= S_ERR;
                busy_q     <= 1'b0;
                error_q    <= 1'b1;
                err_code_q <= 2'd1;
              end else if (bus.cfg_total_blocks == 32'd0) begin
                state  <= S_DONE;
                busy_q <= 1'b1;
                done_q <= 1'b1;
              end else begin
                state  <= S_LOAD;
                busy_q <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            meta_cnt <= meta_next;
            if ((meta_q == 16'd0) || (meta_next == meta_q)) begin
              state         <= S_RUN;
              sched_start_q <= 1'b1;
              wdog          <= '0;
            end else if (bus.dma_word_valid) begin
              wdog <= '0;
            end else if (wd_expire) begin
              state      <= S_ERR;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
              err_code_q <= 2'd3;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          S_RUN: begin
            if (bus.sched_done && !last_hs) begin
              state      <= S_ERR;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
              err_code_q <= 2'd2;
            end else if (last_hs) begin
              state <= S_DRAIN;
              wdog  <= '0;
            end else if (hs) begin
              wdog <= '0;
            end else if (wd_expire) begin
              state      <= S_ERR;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
              err_code_q <= 2'd3;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          S_DRAIN: begin
            if (!bus.sched_busy) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else if (wd_expire) begin
              state      <= S_ERR;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
              err_code_q <= 2'd3;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SPARSE_RUN_PERF_EN
  logic [31:0] perf_q;

  // Saturating count of LOAD/RUN/DRAIN cycles, cleared when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (!bus.cfg_abort && bus.cfg_start &&
                 ((state == S_IDLE) || (state == S_ERR))) begin
      perf_q <= '0;
    end else if (((state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN)) &&
                 (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_sparse_run_ctrl.sv
// Self-checking bench for sparse_run_ctrl: a per-cycle reference model of the
// run rules compared against every output, directed scenarios with literal
// expectations, and a randomized run loop.
`timescale 1ns/1ps
module tb_sparse_run_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int TO    = 16;
  localparam int DEPTH = 1 << AW;

  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DRAIN = 3, P_FIN = 4, P_ERR = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sparse_run_if #(.OUT_ADDR_W(AW), .DATA_W(DW)) bus ();

  sparse_run_ctrl #(.OUT_ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  int          ph;
  int unsigned m_total, m_meta, m_got, m_idle, m_blocks, m_perf, m_addr, m_code;
  logic [31:0] m_data;
  bit          m_ss, m_wen, m_done;

  // observation log
  int          n_done_seen, n_ss_seen;
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    ph = P_IDLE; m_total = 0; m_meta = 0; m_got = 0; m_idle = 0; m_blocks = 0;
    m_perf = 0; m_addr = 0; m_code = 0; m_data = '0; m_ss = 0; m_wen = 0; m_done = 0;
  endfunction

  function automatic void stall();
    m_idle++;
    if (m_idle == TO) begin ph = P_ERR; m_code = 3; end
  endfunction

  function automatic void model_step();
    bit hs;
    bit active;
    hs     = bus.res_valid && (ph == P_RUN);
    active = (ph == P_LOAD) || (ph == P_RUN) || (ph == P_DRAIN);
    m_ss = 0;
    m_wen = hs;
    if (hs) begin
      m_addr = m_blocks & (DEPTH - 1);
      m_data = bus.res_data;
      m_blocks++;
    end
    if (active && m_perf != 32'hFFFF_FFFF) m_perf++;
    if (bus.cfg_abort) begin
      ph = P_IDLE; m_code = 0;
    end else if (ph == P_IDLE || ph == P_ERR) begin
      if (bus.cfg_start) begin
        m_code = 0; m_blocks = 0; m_addr = 0; m_got = 0; m_idle = 0; m_perf = 0;
        m_total = bus.cfg_total_blocks; m_meta = bus.cfg_meta_words;
        if (m_total > DEPTH) begin ph = P_ERR; m_code = 1; end
        else if (m_total == 0) ph = P_FIN;
        else ph = P_LOAD;
      end
    end else if (ph == P_LOAD) begin
      if (bus.dma_word_valid) m_got++;
      if (m_meta == 0 || m_got == m_meta) begin ph = P_RUN; m_ss = 1; m_idle = 0; end
      else if (bus.dma_word_valid) m_idle = 0;
      else stall();
    end else if (ph == P_RUN) begin
      if (bus.sched_done && m_blocks != m_total) begin ph = P_ERR; m_code = 2; end
      else if (m_blocks == m_total) begin ph = P_DRAIN; m_idle = 0; end
      else if (hs) m_idle = 0;
      else stall();
    end else if (ph == P_DRAIN) begin
      if (!bus.sched_busy) ph = P_FIN;
      else stall();
    end else begin
      ph = P_IDLE;
    end
    m_done = (ph == P_FIN);
  endfunction

  task automatic compare_all();
    chk("res_ready",   64'(bus.res_ready),   64'(ph == P_RUN));
    chk("sched_start", 64'(bus.sched_start), 64'(m_ss));
    chk("out_wr_en",   64'(bus.out_wr_en),   64'(m_wen));
    chk("out_wr_addr", 64'(bus.out_wr_addr), 64'(m_addr));
    chk("out_wr_data", 64'(bus.out_wr_data), 64'(m_data));
    chk("busy",        64'(bus.busy),        64'(ph >= P_LOAD && ph <= P_FIN));
    chk("done_pulse",  64'(bus.done_pulse),  64'(m_done));
    chk("error",       64'(bus.error),       64'(ph == P_ERR));
    chk("err_code",    64'(bus.err_code),    64'(m_code));
    chk("blocks_done", 64'(bus.blocks_done), 64'(m_blocks));
`ifdef SPARSE_RUN_PERF_EN
    chk("perf_cycles", 64'(bus.perf_cycles), 64'(m_perf));
`else
    chk("perf_cycles", 64'(bus.perf_cycles), 64'd0);
`endif
  endtask

  // Advance the model on each rising edge and compare just after it.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      compare_all();
      if (bus.out_wr_en) begin
        wlog_addr.push_back(32'(bus.out_wr_addr));
        wlog_data.push_back(bus.out_wr_data);
      end
      if (bus.done_pulse) n_done_seen++;
      if (bus.sched_start) n_ss_seen++;
    end
  end

  task automatic drive_idle();
    bus.cfg_start = 0; bus.cfg_abort = 0; bus.dma_word_valid = 0;
    bus.sched_done = 0; bus.sched_busy = 0; bus.res_valid = 0;
  endtask

  task automatic clear_log();
    wlog_addr.delete(); wlog_data.delete(); n_done_seen = 0; n_ss_seen = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  64'(bus.busy), 64'd0);
    chk({tag, "_done"},  64'(bus.done_pulse), 64'd0);
    chk({tag, "_ss"},    64'(bus.sched_start), 64'd0);
    chk({tag, "_wren"},  64'(bus.out_wr_en), 64'd0);
    chk({tag, "_err"},   64'(bus.error), 64'd0);
    chk({tag, "_blk"},   64'(bus.blocks_done), 64'd0);
    chk({tag, "_ready"}, 64'(bus.res_ready), 64'd0);
  endtask

  task automatic do_abort();
    @(negedge clk); drive_idle(); bus.cfg_abort = 1;
    @(negedge clk); bus.cfg_abort = 0;
  endtask

  // Start a 2-result run with no metadata; a stray result in DRAIN must be ignored.
  task automatic run_two(input string tag, input logic [31:0] base);
    @(negedge clk); drive_idle(); clear_log();
    bus.cfg_total_blocks = 2; bus.cfg_meta_words = 0; bus.cfg_start = 1;
    @(negedge clk); bus.cfg_start = 0;
    chk({tag, "_err_cleared"}, 64'(bus.error), 64'd0);
    bus.res_valid = 1; bus.res_data = base;
    @(negedge clk); bus.res_data = base;
    @(negedge clk); bus.res_data = base + 1;
    @(negedge clk); bus.res_data = 32'hDEAD_BEEF;
    @(negedge clk); bus.res_valid = 0;
    repeat (2) @(negedge clk);
    chk({tag, "_nwrites"}, 64'(wlog_addr.size()), 64'd2);
    for (int i = 0; i < 2 && i < wlog_addr.size(); i++) begin
      chk({tag, "_addr"}, 64'(wlog_addr[i]), 64'(i));
      chk({tag, "_data"}, 64'(wlog_data[i]), 64'(base + 32'(i)));
    end
    chk({tag, "_done_cnt"}, 64'(n_done_seen), 64'd1);
`ifdef SPARSE_RUN_PERF_EN
    chk({tag, "_perf"}, 64'(bus.perf_cycles), 64'd4);
`else
    chk({tag, "_perf"}, 64'(bus.perf_cycles), 64'd0);
`endif
  endtask

  initial begin
    drive_idle();
    bus.cfg_total_blocks = 0; bus.cfg_meta_words = 0; bus.res_data = 0;
    clear_log();
    #1 rst_n = 0;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1;

    // 1: total=4, meta=3
    @(negedge clk); clear_log();
    bus.cfg_total_blocks = 4; bus.cfg_meta_words = 3; bus.cfg_start = 1;
    @(negedge clk); bus.cfg_start = 0; bus.dma_word_valid = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_ss_early", 64'(bus.sched_start), 64'd0);
    @(negedge clk); bus.dma_word_valid = 0; bus.sched_busy = 1;
    chk("t1_ss_timing", 64'(bus.sched_start), 64'd1);
    for (int i = 0; i < 4; i++) begin
      bus.res_valid = 1; bus.res_data = 32'hA0 + 32'(i);
      @(negedge clk);
    end
    bus.res_valid = 0; bus.sched_done = 1;
    @(negedge clk); bus.sched_done = 0; bus.sched_busy = 0;
    repeat (4) @(negedge clk);
    chk("t1_nwrites", 64'(wlog_addr.size()), 64'd4);
    for (int i = 0; i < 4 && i < wlog_addr.size(); i++) begin
      chk("t1_addr", 64'(wlog_addr[i]), 64'(i));
      chk("t1_data", 64'(wlog_data[i]), 64'(32'hA0 + 32'(i)));
    end
    chk("t1_done_cnt", 64'(n_done_seen), 64'd1);
    chk("t1_ss_cnt", 64'(n_ss_seen), 64'd1);
    chk("t1_blocks", 64'(bus.blocks_done), 64'd4);
    chk("t1_error", 64'(bus.error), 64'd0);

    // 2: total=0
    @(negedge clk); clear_log();
    bus.cfg_total_blocks = 0; bus.cfg_meta_words = 2; bus.cfg_start = 1;
    @(negedge clk); bus.cfg_start = 0;
    chk("t2_done", 64'(bus.done_pulse), 64'd1);
    @(negedge clk);
    chk("t2_done_low", 64'(bus.done_pulse), 64'd0);
    chk("t2_busy", 64'(bus.busy), 64'd0);
    chk("t2_ss_cnt", 64'(n_ss_seen), 64'd0);

    // 3: overflow
    @(negedge clk); clear_log();
    bus.cfg_total_blocks = 1025; bus.cfg_meta_words = 0; bus.cfg_start = 1;
    @(negedge clk); bus.cfg_start = 0;
    chk("t3_error", 64'(bus.error), 64'd1);
    chk("t3_code", 64'(bus.err_code), 64'd1);
    chk("t3_busy", 64'(bus.busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("t3_ss_cnt", 64'(n_ss_seen), 64'd0);
    do_abort();
    chk("t3_abort_clr", 64'(bus.error), 64'd0);

    // exactly the BRAM depth is accepted
    @(negedge clk);
    bus.cfg_total_blocks = DEPTH; bus.cfg_start = 1;
    @(negedge clk); bus.cfg_start = 0;
    chk("depth_ok_err", 64'(bus.error), 64'd0);
    chk("depth_ok_busy", 64'(bus.busy), 64'd1);
    do_abort();

    // 4: underrun after 2 of 4
    @(negedge clk); clear_log();
    bus.cfg_total_blocks = 4; bus.cfg_meta_words = 1; bus.cfg_start = 1;
    @(negedge clk); bus.cfg_start = 0; bus.dma_word_valid = 1;
    @(negedge clk); bus.dma_word_valid = 0; bus.sched_busy = 1;
    bus.res_valid = 1; bus.res_data = 32'h11;
    @(negedge clk); bus.res_data = 32'h12;
    @(negedge clk); bus.res_valid = 0; bus.sched_done = 1;
    @(negedge clk); bus.sched_done = 0; bus.res_valid = 1; bus.res_data = 32'h13;
    chk("t4_error", 64'(bus.error), 64'd1);
    chk("t4_code", 64'(bus.err_code), 64'd2);
    chk("t4_ready", 64'(bus.res_ready), 64'd0);
    repeat (2) @(negedge clk);
    chk("t4_nwrites", 64'(wlog_addr.size()), 64'd2);
    run_two("t4_restart", 32'h500);

    // 5: timeout in LOAD
    @(negedge clk); clear_log();
    bus.cfg_total_blocks = 3; bus.cfg_meta_words = 2; bus.cfg_start = 1;
    @(negedge clk); bus.cfg_start = 0;
    repeat (15) @(negedge clk);
    chk("t5_not_yet", 64'(bus.error), 64'd0);
    @(negedge clk);
    chk("t5_error", 64'(bus.error), 64'd1);
    chk("t5_code", 64'(bus.err_code), 64'd3);
    do_abort();

    // 6: abort in RUN after 1 of 4
    @(negedge clk); clear_log();
    bus.cfg_total_blocks = 4; bus.cfg_meta_words = 0; bus.cfg_start = 1;
    @(negedge clk); bus.cfg_start = 0; bus.sched_busy = 1;
    bus.res_valid = 1; bus.res_data = 32'h77;
    @(negedge clk);
    @(negedge clk); bus.res_valid = 0; bus.cfg_abort = 1;
    @(negedge clk); bus.cfg_abort = 0; bus.sched_busy = 0;
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_ready", 64'(bus.res_ready), 64'd0);
    chk("t6_done_cnt", 64'(n_done_seen), 64'd0);
    chk("t6_nwrites", 64'(wlog_addr.size()), 64'd1);
    run_two("t6_rerun", 32'h900);

    // randomized runs
    for (int r = 0; r < 60; r++) begin
      int pick;
      @(negedge clk); drive_idle();
      pick = int'($urandom_range(0, 9));
      if (pick == 0) bus.cfg_total_blocks = 0;
      else if (pick == 1) bus.cfg_total_blocks = DEPTH + $urandom_range(1, 5000);
      else bus.cfg_total_blocks = $urandom_range(1, 6);
      bus.cfg_meta_words = 16'($urandom_range(0, 3));
      bus.cfg_start = 1;
      bus.cfg_abort = ($urandom_range(0, 19) == 0);
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        if (r == 30 && c == 5) begin
          drive_idle();
          rst_n = 0;
          #1 check_zero("async_rst");
          @(negedge clk); rst_n = 1;
        end
        bus.cfg_start      = ($urandom_range(0, 29) == 0);
        bus.cfg_abort      = ($urandom_range(0, 119) == 0);
        bus.dma_word_valid = ($urandom_range(0, 2) != 0);
        bus.res_valid      = ($urandom_range(0, 2) != 0);
        bus.res_data       = $urandom;
        bus.sched_busy     = ($urandom_range(0, 1) == 0);
        bus.sched_done     = ($urandom_range(0, 49) == 0);
        if (r % 7 == 3) begin
          bus.dma_word_valid = 0; bus.res_valid = 0; bus.sched_busy = 1; bus.sched_done = 0;
        end
        if ((ph == P_IDLE || ph == P_ERR) && c > 2) break;
      end
      do_abort();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
